// File: rtl/p_status_unit_if.sv
// Signal bundle between the 6502 sequencer/ALU and the processor status unit.
// The master drives the microcode controls; the slave (status unit) returns P and interrupt requests.
interface p_status_unit_if;
  logic [2:0] p_op;
  logic [7:0] alu_result;
  logic       alu_c;
  logic       alu_v;
  logic       bittest;
  logic       nz_we;
  logic       c_we;
  logic       v_we;
  logic [2:0] flag_sel;
  logic       flag_val;
  logic [7:0] db_in;
  logic       intr_enter;
  logic       push_brk;
  logic       irq_n;
  logic       nmi_n;
  logic       nmi_ack;
  logic [7:0] p_out;
  logic       c_flag;
  logic       d_flag;
  logic       irq_pending;
  logic       nmi_pending;

  modport master (
    output p_op, alu_result, alu_c, alu_v, bittest, nz_we, c_we, v_we,
    output flag_sel, flag_val, db_in, intr_enter, push_brk, irq_n, nmi_n, nmi_ack,
    input  p_out, c_flag, d_flag, irq_pending, nmi_pending
  );

  modport slave (
    input  p_op, alu_result, alu_c, alu_v, bittest, nz_we, c_we, v_we,
    input  flag_sel, flag_val, db_in, intr_enter, push_brk, irq_n, nmi_n, nmi_ack,
    output p_out, c_flag, d_flag, irq_pending, nmi_pending
  );
endinterface

// File: rtl/p_status_unit.sv
// 6502 processor status register (N V D I Z C) with IRQ/NMI synchronisation and latching.
// Flags are updated under microcode control; interrupt entry forces I (and D on the 65C02).
module p_status_unit #(
  parameter bit CMOS = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  p_status_unit_if.slave bus
);

  localparam logic [2:0] OP_ALU    = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_BIT    = 3'd3;
  localparam logic [2:0] OP_SETCLR = 3'd4;

  function automatic logic f_is_zero(input logic [7:0] value);
    return (value == 8'h00);
  endfunction

  logic r_n, r_v, r_d, r_i, r_z, r_c;
  logic w_n_nxt, w_v_nxt, w_z_nxt, w_c_nxt;
  logic w_d_op, w_i_op;
  logic w_d_nxt, w_i_nxt;

  logic r_irq_s1, r_irq_s2;
  logic r_nmi_s1, r_nmi_s2, r_nmi_prev;
  logic r_nmi_latched;
  logic r_irq_pending, r_nmi_pending;
  logic w_nmi_edge;
  logic w_nmi_latched_nxt;

  // Next-state flag values selected by the microcode operation
  always_comb begin
    w_n_nxt = r_n;
    w_v_nxt = r_v;
    w_z_nxt = r_z;
    w_c_nxt = r_c;
    w_d_op  = r_d;
    w_i_op  = r_i;
    case (bus.p_op)
      OP_ALU: begin
        w_n_nxt = bus.nz_we ? bus.alu_result[7]         : r_n;
        w_z_nxt = bus.nz_we ? f_is_zero(bus.alu_result) : r_z;
        w_c_nxt = bus.c_we  ? bus.alu_c                 : r_c;
        w_v_nxt = bus.v_we  ? bus.alu_v                 : r_v;
      end
      OP_LOAD: begin
        w_n_nxt = bus.db_in[7];
        w_v_nxt = bus.db_in[6];
        w_d_op  = bus.db_in[3];
        w_i_op  = bus.db_in[2];
        w_z_nxt = bus.db_in[1];
        w_c_nxt = bus.db_in[0];
      end
      OP_BIT: begin
        // Immediate-mode BIT on the 65C02 touches Z only, so N/V follow nz_we
        w_z_nxt = ~bus.bittest;
        w_n_nxt = bus.nz_we ? bus.db_in[7] : r_n;
        w_v_nxt = bus.nz_we ? bus.db_in[6] : r_v;
      end
      OP_SETCLR: begin
        case (bus.flag_sel)
          3'd0:    w_c_nxt = bus.flag_val;
          3'd1:    w_z_nxt = bus.flag_val;
          3'd2:    w_i_op  = bus.flag_val;
          3'd3:    w_d_op  = bus.flag_val;
          3'd6:    w_v_nxt = bus.flag_val;
          3'd7:    w_n_nxt = bus.flag_val;
          default: w_c_nxt = r_c;
        endcase
      end
      default: w_c_nxt = r_c;
    endcase
  end

  // Interrupt entry takes priority over the microcode operation for I and D
  always_comb begin
    w_i_nxt = bus.intr_enter ? 1'b1 : w_i_op;
    w_d_nxt = (bus.intr_enter && CMOS) ? 1'b0 : w_d_op;
  end

  // NMI falling-edge detect; a fresh edge beats a simultaneous acknowledge
  always_comb begin
    w_nmi_edge        = r_nmi_prev & ~r_nmi_s2;
    w_nmi_latched_nxt = w_nmi_edge | (r_nmi_latched & ~bus.nmi_ack);
  end

  // Status flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_n <= 1'b0;
      r_v <= 1'b0;
      r_d <= 1'b0;
      r_i <= 1'b1;
      r_z <= 1'b0;
      r_c <= 1'b0;
    end else begin
      r_n <= w_n_nxt;
      r_v <= w_v_nxt;
      r_d <= w_d_nxt;
      r_i <= w_i_nxt;
      r_z <= w_z_nxt;
      r_c <= w_c_nxt;
    end
  end

  // Interrupt pin synchronisers, NMI latch and pending requests
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_s1      <= 1'b1;
      r_irq_s2      <= 1'b1;
      r_nmi_s1      <= 1'b1;
      r_nmi_s2      <= 1'b1;
      r_nmi_prev    <= 1'b1;
      r_nmi_latched <= 1'b0;
      r_irq_pending <= 1'b0;
      r_nmi_pending <= 1'b0;
    end else begin
      r_irq_s1      <= bus.irq_n;
      r_irq_s2      <= r_irq_s1;
      r_nmi_s1      <= bus.nmi_n;
      r_nmi_s2      <= r_nmi_s1;
      r_nmi_prev    <= r_nmi_s2;
      r_nmi_latched <= w_nmi_latched_nxt;
      // Uses the I value being written so CLI/SEI take effect on the same edge
      r_irq_pending <= ~r_irq_s2 & ~w_i_nxt;
      r_nmi_pending <= w_nmi_latched_nxt;
    end
  end

  assign bus.p_out       = {r_n, r_v, 1'b1, bus.push_brk, r_d, r_i, r_z, r_c};
  assign bus.c_flag      = r_c;
  assign bus.d_flag      = r_d;
  assign bus.irq_pending = r_irq_pending;
  assign bus.nmi_pending = r_nmi_pending;

endmodule

// File: tb/tb_p_status_unit.sv
// Directed self-checking bench for p_status_unit; an NMOS and a CMOS instance share one stimulus.
module tb_p_status_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  p_status_unit_if if_n ();
  p_status_unit_if if_c ();

  assign if_c.p_op       = if_n.p_op;
  assign if_c.alu_result = if_n.alu_result;
  assign if_c.alu_c      = if_n.alu_c;
  assign if_c.alu_v      = if_n.alu_v;
  assign if_c.bittest    = if_n.bittest;
  assign if_c.nz_we      = if_n.nz_we;
  assign if_c.c_we       = if_n.c_we;
  assign if_c.v_we       = if_n.v_we;
  assign if_c.flag_sel   = if_n.flag_sel;
  assign if_c.flag_val   = if_n.flag_val;
  assign if_c.db_in      = if_n.db_in;
  assign if_c.intr_enter = if_n.intr_enter;
  assign if_c.push_brk   = if_n.push_brk;
  assign if_c.irq_n      = if_n.irq_n;
  assign if_c.nmi_n      = if_n.nmi_n;
  assign if_c.nmi_ack    = if_n.nmi_ack;

  p_status_unit #(.CMOS(1'b0)) u_dut_n (.clk(clk), .reset_n(reset_n), .bus(if_n));
  p_status_unit #(.CMOS(1'b1)) u_dut_c (.clk(clk), .reset_n(reset_n), .bus(if_c));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_n.p_op       = 3'd0;
    if_n.alu_result = 8'h00;
    if_n.alu_c      = 1'b0;
    if_n.alu_v      = 1'b0;
    if_n.bittest    = 1'b0;
    if_n.nz_we      = 1'b0;
    if_n.c_we       = 1'b0;
    if_n.v_we       = 1'b0;
    if_n.flag_sel   = 3'd0;
    if_n.flag_val   = 1'b0;
    if_n.db_in      = 8'h00;
    if_n.intr_enter = 1'b0;
    if_n.nmi_ack    = 1'b0;
  endtask

  task automatic setclr(input logic [2:0] sel, input logic val);
    idle();
    if_n.p_op     = 3'd4;
    if_n.flag_sel = sel;
    if_n.flag_val = val;
  endtask

  task automatic load(input logic [7:0] v);
    idle();
    if_n.p_op  = 3'd2;
    if_n.db_in = v;
  endtask

  task automatic test_reset();
    n_checks++; if (if_n.p_out !== 8'h24) begin n_fail++; $display("FAIL por_p_out: got %h want 24", if_n.p_out); end
    load(8'hFF);
    tick();
    n_checks++; if (if_n.p_out !== 8'hEF) begin n_fail++; $display("FAIL pre_reset_load: got %h want ef", if_n.p_out); end
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++; if (if_n.p_out !== 8'h24) begin n_fail++; $display("FAIL async_rst_p_n: got %h want 24", if_n.p_out); end
    n_checks++; if (if_c.p_out !== 8'h24) begin n_fail++; $display("FAIL async_rst_p_c: got %h want 24", if_c.p_out); end
    n_checks++; if (if_n.c_flag !== 1'b0) begin n_fail++; $display("FAIL async_rst_c: got %b want 0", if_n.c_flag); end
    n_checks++; if (if_n.d_flag !== 1'b0) begin n_fail++; $display("FAIL async_rst_d: got %b want 0", if_n.d_flag); end
    n_checks++; if (if_n.irq_pending !== 1'b0) begin n_fail++; $display("FAIL async_rst_irq: got %b want 0", if_n.irq_pending); end
    n_checks++; if (if_n.nmi_pending !== 1'b0) begin n_fail++; $display("FAIL async_rst_nmi: got %b want 0", if_n.nmi_pending); end
    #2;
    reset_n = 1'b1;
    idle();
    if_n.p_op       = 3'd1;
    if_n.alu_result = 8'h80;
    if_n.nz_we      = 1'b1;
    tick();
    n_checks++; if (if_n.p_out !== 8'hA4) begin n_fail++; $display("FAIL post_rst_alu_n: got %h want a4", if_n.p_out); end
    n_checks++; if (if_c.p_out !== 8'hA4) begin n_fail++; $display("FAIL post_rst_alu_c: got %h want a4", if_c.p_out); end
  endtask

  task automatic test_alu_bit();
    idle();
    if_n.p_op = 3'd1; if_n.alu_result = 8'h00; if_n.alu_c = 1'b1; if_n.alu_v = 1'b1;
    if_n.nz_we = 1'b1; if_n.c_we = 1'b1; if_n.v_we = 1'b1;
    tick();
    n_checks++; if (if_n.p_out !== 8'h67) begin n_fail++; $display("FAIL alu_all_we: got %h want 67", if_n.p_out); end
    n_checks++; if (if_n.c_flag !== 1'b1) begin n_fail++; $display("FAIL alu_c_flag: got %b want 1", if_n.c_flag); end
    idle();
    if_n.p_op = 3'd3; if_n.db_in = 8'hC0; if_n.bittest = 1'b1; if_n.c_we = 1'b1; if_n.v_we = 1'b1;
    tick();
    n_checks++; if (if_n.p_out !== 8'h65) begin n_fail++; $display("FAIL bit_imm: got %h want 65", if_n.p_out); end
    idle();
    if_n.p_op = 3'd3; if_n.db_in = 8'h80; if_n.bittest = 1'b0; if_n.nz_we = 1'b1;
    tick();
    n_checks++; if (if_n.p_out !== 8'hA7) begin n_fail++; $display("FAIL bit_mem: got %h want a7", if_n.p_out); end
    idle();
    if_n.p_op = 3'd1; if_n.alu_v = 1'b1; if_n.alu_result = 8'h01;
    tick();
    n_checks++; if (if_n.p_out !== 8'hA7) begin n_fail++; $display("FAIL alu_no_we: got %h want a7", if_n.p_out); end
    idle();
    if_n.p_op = 3'd5; if_n.db_in = 8'h00; if_n.nz_we = 1'b1; if_n.alu_result = 8'h01;
    tick();
    n_checks++; if (if_n.p_out !== 8'hA7) begin n_fail++; $display("FAIL op5_hold: got %h want a7", if_n.p_out); end
    idle();
    if_n.p_op = 3'd1; if_n.alu_result = 8'h01; if_n.nz_we = 1'b1; if_n.alu_c = 1'b0;
    tick();
    n_checks++; if (if_n.p_out !== 8'h25) begin n_fail++; $display("FAIL alu_nz_only: got %h want 25", if_n.p_out); end
    idle();
    if_n.p_op = 3'd1; if_n.c_we = 1'b1; if_n.alu_c = 1'b0; if_n.alu_v = 1'b1;
    tick();
    n_checks++; if (if_n.p_out !== 8'h24) begin n_fail++; $display("FAIL alu_c_only: got %h want 24", if_n.p_out); end
  endtask

  task automatic test_load_push();
    load(8'hFF);
    tick();
    n_checks++; if (if_n.p_out !== 8'hEF) begin n_fail++; $display("FAIL load_ff: got %h want ef", if_n.p_out); end
    n_checks++; if (if_n.d_flag !== 1'b1) begin n_fail++; $display("FAIL load_ff_d: got %b want 1", if_n.d_flag); end
    if_n.push_brk = 1'b1;
    #1;
    n_checks++; if (if_n.p_out !== 8'hFF) begin n_fail++; $display("FAIL push_brk: got %h want ff", if_n.p_out); end
    if_n.push_brk = 1'b0;
    load(8'h30);
    tick();
    n_checks++; if (if_n.p_out !== 8'h20) begin n_fail++; $display("FAIL load_30: got %h want 20", if_n.p_out); end
  endtask

  task automatic test_setclr();
    logic [7:0] exp_tab [6] = '{8'hA0, 8'hE0, 8'hE0, 8'hE0, 8'hE1, 8'hE3};
    logic [2:0] sel_tab [6] = '{3'd7, 3'd6, 3'd4, 3'd5, 3'd0, 3'd1};
    for (int k = 0; k < 6; k++) begin
      setclr(sel_tab[k], 1'b1);
      tick();
      n_checks++;
      if (if_n.p_out !== exp_tab[k]) begin
        n_fail++; $display("FAIL setclr_sel%0d: got %h want %h", sel_tab[k], if_n.p_out, exp_tab[k]);
      end
    end
    load(8'h00);
    tick();
  endtask

  task automatic test_intr_enter();
    setclr(3'd3, 1'b1);
    tick();
    n_checks++; if (if_c.p_out !== 8'h28) begin n_fail++; $display("FAIL sed_c: got %h want 28", if_c.p_out); end
    setclr(3'd3, 1'b1);
    if_n.intr_enter = 1'b1;
    tick();
    n_checks++; if (if_c.p_out !== 8'h24) begin n_fail++; $display("FAIL intr_cmos: got %h want 24", if_c.p_out); end
    n_checks++; if (if_n.p_out !== 8'h2C) begin n_fail++; $display("FAIL intr_nmos: got %h want 2c", if_n.p_out); end
    n_checks++; if (if_c.d_flag !== 1'b0) begin n_fail++; $display("FAIL intr_cmos_d: got %b want 0", if_c.d_flag); end
    setclr(3'd2, 1'b0);
    tick();
    idle();
    if_n.p_op = 3'd1; if_n.alu_result = 8'h00; if_n.nz_we = 1'b1; if_n.c_we = 1'b1; if_n.alu_c = 1'b1;
    if_n.intr_enter = 1'b1;
    tick();
    n_checks++; if (if_n.p_out !== 8'h2F) begin n_fail++; $display("FAIL intr_alu_n: got %h want 2f", if_n.p_out); end
    n_checks++; if (if_c.p_out !== 8'h27) begin n_fail++; $display("FAIL intr_alu_c: got %h want 27", if_c.p_out); end
    load(8'h04);
    tick();
    idle();
  endtask

  task automatic test_irq();
    if_n.irq_n = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (if_n.irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", if_n.irq_pending); end
    setclr(3'd2, 1'b0);
    tick();
    n_checks++; if (if_n.irq_pending !== 1'b1) begin n_fail++; $display("FAIL irq_cli_edge: got %b want 1", if_n.irq_pending); end
    n_checks++; if (if_n.p_out !== 8'h20) begin n_fail++; $display("FAIL cli_p_out: got %h want 20", if_n.p_out); end
    idle();
    if_n.irq_n = 1'b1;
    tick(); tick();
    n_checks++; if (if_n.irq_pending !== 1'b1) begin n_fail++; $display("FAIL irq_release_e2: got %b want 1", if_n.irq_pending); end
    tick();
    n_checks++; if (if_n.irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_release_e3: got %b want 0", if_n.irq_pending); end
    if_n.irq_n = 1'b0;
    tick(); tick();
    n_checks++; if (if_n.irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_fall_e2: got %b want 0", if_n.irq_pending); end
    tick();
    n_checks++; if (if_n.irq_pending !== 1'b1) begin n_fail++; $display("FAIL irq_fall_e3: got %b want 1", if_n.irq_pending); end
    setclr(3'd2, 1'b1);
    tick();
    n_checks++; if (if_n.irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_sei_edge: got %b want 0", if_n.irq_pending); end
    setclr(3'd2, 1'b0);
    tick();
    idle();
    if_n.intr_enter = 1'b1;
    tick();
    n_checks++; if (if_n.irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_intr_edge: got %b want 0", if_n.irq_pending); end
    n_checks++; if (if_n.p_out !== 8'h24) begin n_fail++; $display("FAIL intr_p_out: got %h want 24", if_n.p_out); end
    idle();
    if_n.irq_n = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_nmi();
    if_n.nmi_n = 1'b0;
    tick(); tick();
    n_checks++; if (if_n.nmi_pending !== 1'b0) begin n_fail++; $display("FAIL nmi_e2: got %b want 0", if_n.nmi_pending); end
    tick();
    n_checks++; if (if_n.nmi_pending !== 1'b1) begin n_fail++; $display("FAIL nmi_e3: got %b want 1", if_n.nmi_pending); end
    if_n.nmi_ack = 1'b1;
    tick();
    if_n.nmi_ack = 1'b0;
    n_checks++; if (if_n.nmi_pending !== 1'b0) begin n_fail++; $display("FAIL nmi_ack: got %b want 0", if_n.nmi_pending); end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (if_n.nmi_pending !== 1'b0) begin n_fail++; $display("FAIL nmi_held_low%0d: got %b want 0", k, if_n.nmi_pending); end
    end
    if_n.nmi_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    if_n.nmi_n = 1'b0;
    tick(); tick();
    if_n.nmi_ack = 1'b1;
    tick();
    n_checks++; if (if_n.nmi_pending !== 1'b1) begin n_fail++; $display("FAIL nmi_edge_vs_ack: got %b want 1", if_n.nmi_pending); end
    if_n.nmi_ack = 1'b0;
    tick();
    n_checks++; if (if_n.nmi_pending !== 1'b1) begin n_fail++; $display("FAIL nmi_stays: got %b want 1", if_n.nmi_pending); end
    if_n.nmi_ack = 1'b1;
    tick();
    if_n.nmi_ack = 1'b0;
    n_checks++; if (if_n.nmi_pending !== 1'b0) begin n_fail++; $display("FAIL nmi_ack2: got %b want 0", if_n.nmi_pending); end
    if_n.nmi_n = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    if_n.push_brk = 1'b0;
    if_n.irq_n    = 1'b1;
    if_n.nmi_n    = 1'b1;
    #12;
    reset_n = 1'b1;
    test_reset();
    test_alu_bit();
    test_load_push();
    test_setclr();
    test_intr_enter();
    test_irq();
    test_nmi();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
